// File: rtl/risc_result_checker.sv
// Result scoreboard: compares each finished ALU result against the expected-output ROM word,
// tallies pass/fail, records the first mismatching vector and flags results that arrive outside a run.
module risc_result_checker #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 3,
   parameter int unsigned NUM_VECTORS = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic              i_res_valid,
   input  logic [DATA_W-1:0] i_res_data,
   output logic              o_exp_en,
   output logic [ADDR_W-1:0] o_exp_addr,
   input  logic [DATA_W-1:0] i_exp_data,
   output logic              o_busy,
   output logic              o_all_done,
   output logic              o_succ,
   output logic [ADDR_W:0]   o_pass_cnt,
   output logic [ADDR_W:0]   o_fail_cnt,
   output logic              o_first_fail_vld,
   output logic [ADDR_W-1:0] o_first_fail_idx,
   output logic              o_res_drop
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_VECTORS - 1);

   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W:0]   r_pass_cnt;
   logic [ADDR_W:0]   r_fail_cnt;
   logic              r_ff_vld;
   logic [ADDR_W-1:0] r_ff_idx;
   logic              r_res_drop;
   logic              r_skid_full;
   logic [DATA_W-1:0] r_skid_data;

   logic              w_cmp_go;
   logic [DATA_W-1:0] w_cmp_data;
   logic              w_match;

   // A result caught during FETCH waits in the skid until the ROM word is valid.
   assign w_cmp_go   = (r_state == ST_WAIT) && (r_skid_full || i_res_valid);
   assign w_cmp_data = r_skid_full ? r_skid_data : i_res_data;
   assign w_match    = (w_cmp_data == i_exp_data);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= '0;
         r_pass_cnt  <= '0;
         r_fail_cnt  <= '0;
         r_ff_vld    <= 1'b0;
         r_ff_idx    <= '0;
         r_res_drop  <= 1'b0;
         r_skid_full <= 1'b0;
         r_skid_data <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_res_valid) r_res_drop <= 1'b1;
               if (i_start) begin
                  r_state     <= ST_FETCH;
                  r_idx       <= '0;
                  r_pass_cnt  <= '0;
                  r_fail_cnt  <= '0;
                  r_ff_vld    <= 1'b0;
                  r_ff_idx    <= '0;
                  r_skid_full <= 1'b0;
                  // A result coinciding with start is still a drop.
                  r_res_drop  <= i_res_valid;
               end
            end
            ST_FETCH: begin
               if (i_res_valid) begin
                  r_skid_full <= 1'b1;
                  r_skid_data <= i_res_data;
               end
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (w_cmp_go) begin
                  r_skid_full <= 1'b0;
                  if (w_match) begin
                     r_pass_cnt <= r_pass_cnt + 1'b1;
                  end else begin
                     r_fail_cnt <= r_fail_cnt + 1'b1;
                     if (!r_ff_vld) begin
                        r_ff_vld <= 1'b1;
                        r_ff_idx <= r_idx;
                     end
                  end
                  if (r_idx == LAST_IDX) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_FETCH;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy           = (r_state == ST_FETCH) || (r_state == ST_WAIT);
   assign o_exp_en         = o_busy;
   assign o_exp_addr       = r_idx;
   assign o_all_done       = (r_state == ST_DONE);
   assign o_succ           = (r_state == ST_DONE) && (r_fail_cnt == '0);
   assign o_pass_cnt       = r_pass_cnt;
   assign o_fail_cnt       = r_fail_cnt;
   assign o_first_fail_vld = r_ff_vld;
   assign o_first_fail_idx = r_ff_idx;
   assign o_res_drop       = r_res_drop;

endmodule

// File: tb/tb_risc_result_checker.sv
// Directed bench for risc_result_checker with a behavioural expected-output ROM.
module tb_risc_result_checker;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        res_valid;
   logic [15:0] res_data;
   logic        exp_en;
   logic [2:0]  exp_addr;
   logic [15:0] exp_data;
   logic        busy;
   logic        all_done;
   logic        succ;
   logic [3:0]  pass_cnt;
   logic [3:0]  fail_cnt;
   logic        ff_vld;
   logic [2:0]  ff_idx;
   logic        res_drop;

   logic [15:0] rom [8];
   logic [15:0] res [8];
   int          n_tests;
   int          n_fail;

   risc_result_checker #(
      .DATA_W     (16),
      .ADDR_W     (3),
      .NUM_VECTORS(8)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_start         (start),
      .i_res_valid     (res_valid),
      .i_res_data      (res_data),
      .o_exp_en        (exp_en),
      .o_exp_addr      (exp_addr),
      .i_exp_data      (exp_data),
      .o_busy          (busy),
      .o_all_done      (all_done),
      .o_succ          (succ),
      .o_pass_cnt      (pass_cnt),
      .o_fail_cnt      (fail_cnt),
      .o_first_fail_vld(ff_vld),
      .o_first_fail_idx(ff_idx),
      .o_res_drop      (res_drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous ROM: word valid one clock after address/enable.
   always @(posedge clk) begin
      if (exp_en) exp_data <= rom[exp_addr];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_start(input logic with_res);
      start     = 1'b1;
      res_valid = with_res;
      res_data  = 16'h5555;
      tick();
      start     = 1'b0;
      res_valid = 1'b0;
   endtask

   // Entered in FETCH; leaves after the compare edge.
   task automatic feed(input int i, input bit skid);
      if (skid) begin
         res_valid = 1'b1;
         res_data  = res[i];
         tick();
         res_valid = 1'b0;
         res_data  = 16'h0;
         tick();
      end else begin
         tick();
         tick();
         res_valid = 1'b1;
         res_data  = res[i];
         tick();
         res_valid = 1'b0;
         res_data  = 16'h0;
      end
   endtask

   task automatic run(input bit skid);
      do_start(1'b0);
      for (int i = 0; i < 8; i++) feed(i, skid);
   endtask

   task automatic check_end(input string tag, input int p, input int f, input logic v,
                            input int idx, input logic s);
      check({tag, ".all_done"}, 32'(all_done), 32'd1);
      check({tag, ".busy"}, 32'(busy), 32'd0);
      check({tag, ".pass_cnt"}, 32'(pass_cnt), 32'(p));
      check({tag, ".fail_cnt"}, 32'(fail_cnt), 32'(f));
      check({tag, ".ff_vld"}, 32'(ff_vld), 32'(v));
      if (v) check({tag, ".ff_idx"}, 32'(ff_idx), 32'(idx));
      check({tag, ".succ"}, 32'(succ), 32'(s));
   endtask

   task automatic load_good();
      for (int i = 0; i < 8; i++) res[i] = 16'(i + 1);
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      start     = 1'b0;
      res_valid = 1'b0;
      res_data  = 16'h0;
      exp_data  = 16'h0;
      for (int i = 0; i < 8; i++) rom[i] = 16'(i + 1);
      rst_n = 1'b0;
      #12;
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.exp_en", 32'(exp_en), 32'd0);
      check("rst.all_done", 32'(all_done), 32'd0);
      check("rst.succ", 32'(succ), 32'd0);
      check("rst.pass_cnt", 32'(pass_cnt), 32'd0);
      check("rst.res_drop", 32'(res_drop), 32'd0);
      rst_n = 1'b1;
      tick();

      // T5a: result in IDLE is dropped, start clears the flag
      res_valid = 1'b1;
      res_data  = 16'h1234;
      tick();
      res_valid = 1'b0;
      check("t5.drop_idle", 32'(res_drop), 32'd1);
      check("t5.idle_busy", 32'(busy), 32'd0);

      // T1: all correct, normal path
      load_good();
      do_start(1'b0);
      check("t1.drop_clr", 32'(res_drop), 32'd0);
      check("t1.busy", 32'(busy), 32'd1);
      check("t1.addr0", 32'(exp_addr), 32'd0);
      for (int i = 0; i < 8; i++) feed(i, 1'b0);
      check_end("t1", 8, 0, 1'b0, 0, 1'b1);

      // T2: result 5 wrong
      res[5] = 16'hBEEF;
      run(1'b0);
      check_end("t2", 7, 1, 1'b1, 5, 1'b0);

      // T3: every result arrives in FETCH, goes through the skid
      load_good();
      do_start(1'b0);
      for (int i = 0; i < 4; i++) feed(i, 1'b1);
      check("t3.mid_pass", 32'(pass_cnt), 32'd4);
      check("t3.mid_addr", 32'(exp_addr), 32'd4);
      for (int i = 4; i < 8; i++) feed(i, 1'b1);
      check_end("t3", 8, 0, 1'b0, 0, 1'b1);

      // T3b: skid path with a mismatch at 3
      res[3] = 16'h0000;
      run(1'b1);
      check_end("t3b", 7, 1, 1'b1, 3, 1'b0);
      load_good();

      // T4: reset after 3 compares
      do_start(1'b0);
      for (int i = 0; i < 3; i++) feed(i, 1'b0);
      check("t4.pre_pass", 32'(pass_cnt), 32'd3);
      rst_n = 1'b0;
      #1;
      check("t4.busy", 32'(busy), 32'd0);
      check("t4.exp_en", 32'(exp_en), 32'd0);
      check("t4.addr", 32'(exp_addr), 32'd0);
      check("t4.pass_cnt", 32'(pass_cnt), 32'd0);
      #3;
      rst_n = 1'b1;
      tick();
      run(1'b0);
      check_end("t4.rerun", 8, 0, 1'b0, 0, 1'b1);

      // T5b: start while busy ignored; start+res_valid from DONE drops the result
      do_start(1'b1);
      check("t5.drop_start", 32'(res_drop), 32'd1);
      check("t5.busy", 32'(busy), 32'd1);
      feed(0, 1'b0);
      feed(1, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t5.addr_kept", 32'(exp_addr), 32'd2);
      check("t5.pass_kept", 32'(pass_cnt), 32'd2);
      // now in WAIT for vector 2
      tick();
      res_valid = 1'b1;
      res_data  = res[2];
      tick();
      res_valid = 1'b0;
      for (int i = 3; i < 8; i++) feed(i, 1'b0);
      check_end("t5", 8, 0, 1'b0, 0, 1'b1);
      check("t5.drop_sticky", 32'(res_drop), 32'd1);

      // T6: back-to-back runs, first with failures at 2 and 6
      res[2] = 16'hFFFF;
      res[6] = 16'h0070;
      run(1'b0);
      check_end("t6.run1", 6, 2, 1'b1, 2, 1'b0);
      load_good();
      run(1'b0);
      check_end("t6.run2", 8, 0, 1'b0, 0, 1'b1);
      check("t6.drop", 32'(res_drop), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
